// File: rtl/key_sw_capture_if.sv
// Avalon-MM slave port bundle for key_sw_capture: 2-bit word address, 32-bit data.
// A strobe sampled high at an edge completes at that edge (no wait states); readdata loads at that edge and holds until the next read.
interface key_sw_capture_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/key_sw_capture.sv
// Board KEY/SW capture: 2-flop sync, per-input debounce, sticky edge events,
// per-key press counters and a masked press interrupt behind a 4-word Avalon slave.
module key_sw_capture #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int N_KEY           = 3,
    parameter int N_SW            = 3
) (
    input  logic             fpga_clk_50,
    input  logic             hps_fpga_reset_n,
    input  logic [N_KEY-1:0] key_i,
    input  logic [N_SW-1:0]  sw_i,
    key_sw_capture_if.slave  avs,
    output logic             irq_o,
    output logic [N_KEY-1:0] key_db_o,
    output logic [N_SW-1:0]  sw_db_o
);
    localparam int              N_IN      = N_KEY + N_SW;
    localparam int              CW        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_IN-1:0] SYNC_IDLE = {{N_SW{1'b0}}, {N_KEY{1'b1}}};

    logic [N_IN-1:0]  sync1;
    logic [N_IN-1:0]  sync2;
    logic [N_IN-1:0]  level;
    logic [N_IN-1:0]  db;
    logic [N_IN-1:0]  toggle;
    logic [CW-1:0]    db_cnt [N_IN];
    logic [N_KEY-1:0] press;
    logic [N_KEY-1:0] rel;
    logic [N_SW-1:0]  sw_tog;
    logic [31:0]      edge_set;
    logic [31:0]      edge_q;
    logic [31:0]      rd_mux;
    logic [31:0]      readdata_q;
    logic [N_KEY-1:0] mask_q;
    logic [7:0]       press_cnt [N_KEY];
    logic             wr_edge;
    logic             wr_mask;
    logic             wr_cnt;

    // Keys are inverted here so every debounced bit reads high = active.
    assign level = sync2 ^ SYNC_IDLE;

    always_comb begin
        toggle = '0;
        for (int i = 0; i < N_IN; i++) begin
            toggle[i] = (level[i] != db[i]) && (db_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge fpga_clk_50) begin
        if (!hps_fpga_reset_n) begin
            sync1 <= SYNC_IDLE;
            sync2 <= SYNC_IDLE;
            db    <= '0;
            for (int i = 0; i < N_IN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= {sw_i, key_i};
            sync2 <= sync1;
            for (int i = 0; i < N_IN; i++) begin
                if ((level[i] == db[i]) || toggle[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
                if (toggle[i]) begin
                    db[i] <= ~db[i];
                end
            end
        end
    end

    assign key_db_o = db[N_KEY-1:0];
    assign sw_db_o  = db[N_IN-1:N_KEY];

    // Events fire on the same edge the debounced level flips.
    assign press  = toggle[N_KEY-1:0] & ~db[N_KEY-1:0];
    assign rel    = toggle[N_KEY-1:0] & db[N_KEY-1:0];
    assign sw_tog = toggle[N_IN-1:N_KEY];

    always_comb begin
        edge_set            = '0;
        edge_set[N_KEY-1:0] = press;
        edge_set[8 +: N_KEY] = rel;
        edge_set[16 +: N_SW] = sw_tog;
    end

    assign wr_edge = avs.avs_write && (avs.avs_address == 2'd1);
    assign wr_mask = avs.avs_write && (avs.avs_address == 2'd2);
    assign wr_cnt  = avs.avs_write && (avs.avs_address == 2'd3);

    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            2'd0: begin
                rd_mux[N_KEY-1:0] = db[N_KEY-1:0];
                rd_mux[8 +: N_SW] = db[N_IN-1:N_KEY];
            end
            2'd1: rd_mux = edge_q;
            2'd2: rd_mux[N_KEY-1:0] = mask_q;
            default: begin
                for (int i = 0; i < N_KEY; i++) begin
                    rd_mux[8*i +: 8] = press_cnt[i];
                end
            end
        endcase
    end

    // Set has priority over W1C, and a press during a clear leaves a count of 1.
    always_ff @(posedge fpga_clk_50) begin
        if (!hps_fpga_reset_n) begin
            edge_q     <= '0;
            mask_q     <= '0;
            readdata_q <= '0;
            for (int i = 0; i < N_KEY; i++) begin
                press_cnt[i] <= '0;
            end
        end else begin
            if (wr_edge) begin
                edge_q <= (edge_q & ~avs.avs_writedata) | edge_set;
            end else begin
                edge_q <= edge_q | edge_set;
            end
            if (wr_mask) begin
                mask_q <= avs.avs_writedata[N_KEY-1:0];
            end
            for (int i = 0; i < N_KEY; i++) begin
                press_cnt[i] <= (wr_cnt ? 8'd0 : press_cnt[i]) + {7'd0, press[i]};
            end
            if (avs.avs_read) begin
                readdata_q <= rd_mux;
            end
        end
    end

    assign avs.avs_readdata = readdata_q;
    assign irq_o = |(edge_q[N_KEY-1:0] & mask_q);
endmodule
